// File: rtl/rover_pkg.sv
// Shared rover definitions: UART byte width and the transmit feeder FSM encoding.
package rover_pkg;
  localparam int UART_DATA_W  = 8;
  localparam int GUARD_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer write handshake plus the start/data/ready link to the UART transmitter.
interface uart_tx_feeder_if;
  logic                             wr_valid;
  logic [rover_pkg::UART_DATA_W-1:0] wr_data;
  logic                             wr_ready;
  logic                             tx_start;
  logic [rover_pkg::UART_DATA_W-1:0] tx_data;
  logic                             tx_ready;

  modport slave  (input  wr_valid, wr_data, tx_ready,
                  output wr_ready, tx_start, tx_data);
  modport master (output wr_valid, wr_data, tx_ready,
                  input  wr_ready, tx_start, tx_data);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with a show-ahead head; shared with the receive path.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; stale bytes are never visible because count gates the head.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Pointers are exactly PTR_W bits, so DEPTH-1 -> 0 wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: one start pulse per byte, paced by tx_ready.
module uart_tx_feeder
  import rover_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_feeder_if.slave  bus,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             idle
);
  feeder_state_e          state_q, state_d;
  logic [1:0]             guard_q;
  logic [UART_DATA_W-1:0] head, tx_data_q;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_W), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_valid),
    .din   (bus.wr_data),
    .pop   (state_q == ISSUE),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign bus.wr_ready = ~full;
  assign bus.tx_start = (state_q == ISSUE);
  assign bus.tx_data  = tx_data_q;
  assign idle         = empty & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty && bus.tx_ready) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      // Guard exit covers a transmitter that never dropped ready for our start.
      WAIT_BUSY: if (!bus.tx_ready || guard_q == 2'(GUARD_CYCLES - 1)) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      guard_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= (state_q == WAIT_BUSY) ? guard_q + 1'b1 : 2'd0;
      // Capture the head on entry to ISSUE so tx_data is valid alongside tx_start.
      if (state_q == IDLE && state_d == ISSUE) tx_data_q <= head;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against a queue model and a behavioural transmitter.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] count;
  logic             empty, full, idle;

  uart_tx_feeder_if bus();

  uart_tx_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .count(count), .empty(empty), .full(full), .idle(idle)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0, cyc = 0;
  logic [7:0] q[$];
  logic [7:0] emitted[$];
  int start_cyc[$];
  logic [7:0] last_data = 8'h00;
  bit  prev_start = 1'b0, push_on_start = 1'b0;
  int  busy = 0, busy_len = 0, starts = 0, ready_run = 0;
  // 0: always ready, 1: busy for busy_len after each start, 2: held low, 3: random busy
  int  mode = 0;

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compare at the falling edge, then set inputs and advance the model for the next rising edge.
  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    int sz; bit st; bit pushed; int len;
    @(negedge clk);
    cyc++;
    sz = q.size();
    st = bus.tx_start;
    check("count", int'(count), sz);
    check("empty", int'(empty), int'(sz == 0));
    check("full", int'(full), int'(sz == DEPTH));
    check("wr_ready", int'(bus.wr_ready), int'(sz != DEPTH));
    check("idle_empty", int'(idle && sz != 0), 0);
    if (st) begin
      check("start_nonempty", int'(sz > 0), 1);
      check("start_ready", int'(bus.tx_ready), 1);
      check("start_pulse", int'(prev_start), 0);
      if (sz > 0) check("tx_data", int'(bus.tx_data), int'(q[0]));
      last_data = bus.tx_data;
      starts++;
      start_cyc.push_back(cyc);
      emitted.push_back(bus.tx_data);
    end else begin
      check("tx_data_hold", int'(bus.tx_data), int'(last_data));
    end
    if (sz > 0 && bus.tx_ready && !st) ready_run++; else ready_run = 0;
    check("lockup", int'(ready_run > 8), 0);

    if (push_on_start) v = st;
    pushed = v && (sz != DEPTH) && !r;
    if (st && sz > 0) void'(q.pop_front());
    if (pushed) q.push_back(d);
    if (r) begin q.delete(); last_data = 8'h00; end
    prev_start = st && !r;
    if (st) begin
      len = (mode == 1) ? busy_len : (mode == 3) ? int'($urandom_range(0, 5)) : 0;
      busy = len;
    end
    if (mode == 2) bus.tx_ready = 1'b0;
    else if (busy > 0) begin bus.tx_ready = 1'b0; busy--; end
    else bus.tx_ready = 1'b1;
    bus.wr_valid = v;
    bus.wr_data  = d;
    rst = r;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(idle && q.size() == 0 && busy == 0 && bus.tx_ready)) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
      if (n > bound) begin
        vec++; err++;
        $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        break;
      end
    end
  endtask

  initial begin
    int w, s0, tgt, n;
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then a single byte into an empty FIFO with the transmitter idle
    tick(1'b0, 8'h00, 1'b0);
    check("rst_idle", int'(idle), 1);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_tx_start", int'(bus.tx_start), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    mode = 0;
    tick(1'b0, 8'h00, 1'b0);
    start_cyc.delete();
    tick(1'b1, 8'hA5, 1'b0);
    w = cyc;
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    check("a5_starts", start_cyc.size(), 1);
    if (start_cyc.size() > 0) check("a5_latency", start_cyc[0] - w, 2);
    check("a5_data", int'(bus.tx_data), 8'hA5);
    check("a5_count", int'(count), 0);
    wait_idle(50);

    // Fill to full with the transmitter held busy; the 17th byte must be held off
    mode = 2;
    tick(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 16; i++) tick(1'b1, 8'(i), 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_wr_ready", int'(bus.wr_ready), 0);
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("fill_count", int'(count), 16);
    emitted.delete();
    mode = 1; busy_len = 2;
    wait_idle(400);
    check("fill_emitted", emitted.size(), 16);
    for (int i = 0; i < 16 && i < emitted.size(); i++) check("fill_order", int'(emitted[i]), i + 1);

    // Slow transmitter: 1000 busy cycles per byte, one start per busy period
    mode = 1; busy_len = 1000;
    s0 = starts;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0);
    wait_idle(5000);
    check("slow_starts", starts - s0, 3);

    // Transmitter never drops ready: guard timeout paces starts 7 cycles apart
    mode = 0;
    start_cyc.delete();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h50 + 8'(i), 1'b0);
    wait_idle(100);
    check("guard_starts", start_cyc.size(), 3);
    if (start_cyc.size() == 3) begin
      check("guard_gap0", start_cyc[1] - start_cyc[0], 7);
      check("guard_gap1", start_cyc[2] - start_cyc[1], 7);
    end

    // Simultaneous push/pop at count 5 across 3*DEPTH bytes (pointer wrap)
    mode = 2;
    tick(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("pp_pre_count", int'(count), 5);
    mode = 0;
    push_on_start = 1'b1;
    tgt = starts + 3 * DEPTH;
    n = 0;
    while (starts < tgt && n < 1000) begin tick(1'b0, 8'($urandom), 1'b0); n++; end
    push_on_start = 1'b0;
    check("pp_done", int'(starts >= tgt), 1);
    check("pp_count", int'(count), 5);
    wait_idle(100);

    // Random traffic against a randomly paced transmitter
    mode = 3;
    for (int i = 0; i < 1500; i++) tick(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    wait_idle(600);

    // Reset with 7 bytes queued while the FSM waits for the transmitter to finish
    mode = 1; busy_len = 50;
    for (int i = 0; i < 8; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    check("rst_pre_count", int'(count), 7);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_idle", int'(idle), 1);
    check("rst_mid_tx_start", int'(bus.tx_start), 0);
    check("rst_mid_tx_data", int'(bus.tx_data), 0);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO depth in bytes; legal values are powers of two from 2 to 256.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, SHALL set the width of the occupancy count.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-005 Port wr_valid, input, 1, SHALL mark the producer byte as valid.
REQ-006 Port wr_data, input, 8, SHALL carry the producer byte.
REQ-007 Port wr_ready, output, 1, SHALL indicate the FIFO accepts a byte this cycle.
REQ-008 Port tx_start, output, 1, SHALL be the one-cycle start pulse to the UART transmitter.
REQ-009 Port tx_data, output, 8, SHALL carry the byte presented with tx_start.
REQ-010 Port tx_ready, input, 1, SHALL be the transmitter-idle indication.
REQ-011 Port count, output, CNT_W, SHALL give the number of bytes held (0..DEPTH).
REQ-012 Port empty, output, 1, SHALL equal (count==0).
REQ-013 Port full, output, 1, SHALL equal (count==DEPTH).
REQ-014 Port idle, output, 1, SHALL be high when empty and the FSM is in IDLE.

Function
REQ-015 A write SHALL occur on any cycle with wr_valid & wr_ready; wr_ready SHALL equal !full, registered-free, with no dependence on a same-cycle pop.
REQ-016 The FIFO SHALL be a circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 A same-cycle push and pop SHALL leave count unchanged and store/retrieve the correct bytes.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE SHALL move to ISSUE when !empty & tx_ready.
REQ-020 In ISSUE, tx_start SHALL be 1 for exactly one cycle, tx_data SHALL equal the FIFO head, the head SHALL be popped in the same cycle, and the FSM SHALL then move to WAIT_BUSY.
REQ-021 WAIT_BUSY SHALL move to WAIT_DONE when tx_ready==0.
REQ-022 WAIT_BUSY SHALL also move to WAIT_DONE after 4 cycles with tx_ready still 1, to guard against a missed start.
REQ-023 WAIT_DONE SHALL move to IDLE when tx_ready==1.
REQ-024 tx_data SHALL be registered and held stable from ISSUE until the next ISSUE.
REQ-025 tx_start SHALL be 0 in every state other than ISSUE.
REQ-026 Bytes SHALL be transmitted in strict write order, and none SHALL be dropped or duplicated.
REQ-027 Minimum latency from a write into an empty FIFO with the transmitter idle SHALL be 2 cycles from the write edge to tx_start high.
REQ-028 wr_valid while full SHALL be back-pressured (wr_ready=0); no data SHALL be lost and no error SHALL be flagged.

Reset
REQ-029 On rst=1 at a clock edge, pointers and count SHALL clear to 0, the FSM SHALL go to IDLE, tx_start SHALL be 0, and tx_data SHALL be 8'h00.
REQ-030 After reset, empty=1, full=0, wr_ready=1 and idle=1.
REQ-031 Reset mid-transfer SHALL discard all FIFO contents; the transmitter's in-flight byte is not the feeder's concern.
REQ-032 No output SHALL rely on an initial-value assignment.

Structure
REQ-033 UART_DATA_W (8) and the feeder FSM state enum SHALL live in the shared rover package.
REQ-034 The FIFO SHALL be a separate sub-module sync_fifo (parameters DEPTH and WIDTH), reusable by the receive path.
REQ-035 The FSM and start/data registers SHALL reside in uart_tx_feeder.

Verification
REQ-036 Reset, then write 8'hA5 with tx_ready=1 -> tx_start pulses once, 2 cycles after the write, with tx_data=8'hA5; count returns to 0.
REQ-037 Write 8'h01..8'h10 (16 bytes) while tx_ready=0 -> full=1 and wr_ready=0; a 17th byte is held off; on releasing tx_ready the bytes emerge in order 8'h01..8'h10.
REQ-038 Model the transmitter with tx_ready low for 1000 cycles per byte -> exactly one tx_start per low-then-high tx_ready cycle; no start occurs while tx_ready=0.
REQ-039 Hold tx_ready=1 permanently after a start -> the 4-cycle guard fires and the next byte issues; verify there is no lockup.
REQ-040 Push and pop in the same cycle at count=5 -> count stays 5, with the pointer wrap checked across 3×DEPTH bytes.
REQ-041 Assert rst while count=7 and in WAIT_DONE -> next cycle count=0, idle=1, tx_start=0.
